mix_add_char: RTL and testbench

Arithmetic/conversion datapath slice for the MIX-1009 CPU core. It holds two independent engines. The ADD engine performs MIX sign-magnitude addition of two 31-bit words (sign bit 30, 30-bit magnitude) and reports overflow. The CHAR engine converts a 30-bit magnitude into ten MIX decimal character codes. The sequencer pulses a start input, waits for the matching stop pulse, then writes rA/rX.

---
 rtl/mix_add_char.sv | 173 +++++++++++++++++
 tb/tb_mix_add_char.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mix_add_char.sv
// MIX-1009 arithmetic/conversion slice: sign-magnitude ADD engine and a 30-bit
// binary-to-character CHAR engine. Define MIX_CHAR_EN to build the full CHAR engine.
module mix_add_char (
  input  logic        clk,
  input  logic        reset,
  input  logic        add_start,
  input  logic [30:0] add_a,
  input  logic [30:0] add_b,
  output logic        add_stop,
  output logic [30:0] add_out,
  output logic        add_overflow,
  input  logic        char_start,
  input  logic [29:0] char_in,
  output logic        char_busy,
  output logic        char_stop,
  output logic [59:0] char_out
);

  localparam int unsigned MAG_W    = 30;
  localparam int unsigned DIGITS   = 10;
  localparam int unsigned CODE_W   = 6;
  localparam int unsigned CHAR_W   = DIGITS * CODE_W;
  localparam int unsigned CNT_W    = 5;
  localparam logic [CODE_W-1:0] CODE_ZERO = CODE_W'(30);

  // ---------------- ADD engine ----------------
  logic              add_stop_q;
  logic [30:0]       add_out_q, add_out_d;
  logic              add_ovf_q, add_ovf_d;
  logic [MAG_W-1:0]  mag_a_w, mag_b_w;
  logic [MAG_W:0]    mag_sum_w;

  assign mag_a_w   = add_a[MAG_W-1:0];
  assign mag_b_w   = add_b[MAG_W-1:0];
  assign mag_sum_w = {1'b0, mag_a_w} + {1'b0, mag_b_w};

  // Equal magnitudes with opposite signs fall into the >= branch, keeping add_a's sign.
  always_comb begin
    add_out_d = add_out_q;
    add_ovf_d = add_ovf_q;
    if (add_a[MAG_W] == add_b[MAG_W]) begin
      add_out_d = {add_a[MAG_W], mag_sum_w[MAG_W-1:0]};
      add_ovf_d = mag_sum_w[MAG_W];
    end else if (mag_a_w >= mag_b_w) begin
      add_out_d = {add_a[MAG_W], mag_a_w - mag_b_w};
      add_ovf_d = 1'b0;
    end else begin
      add_out_d = {add_b[MAG_W], mag_b_w - mag_a_w};
      add_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_stop_q <= 1'b0;
      add_out_q  <= '0;
      add_ovf_q  <= 1'b0;
    end else begin
      add_stop_q <= add_start;
      if (add_start) begin
        add_out_q <= add_out_d;
        add_ovf_q <= add_ovf_d;
      end
    end
  end

  assign add_stop     = add_stop_q;
  assign add_out      = add_out_q;
  assign add_overflow = add_ovf_q;

  // ---------------- CHAR engine ----------------
`ifdef MIX_CHAR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t             state_q;
  logic [MAG_W-1:0]   bin_q;
  logic [38:0]        bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, stop_q;
  logic [CHAR_W-1:0]  char_out_q;
  logic [35:0]        bcd_adj_w;
  logic [39:0]        bcd_step_w;
  logic [CHAR_W-1:0]  char_pack_w;

  // Add-3 on the nine low digits; the top digit stays below 5 for any 30-bit input.
  always_comb begin
    bcd_adj_w = bcd_q[35:0];
    for (int i = 0; i < 9; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj_w[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_step_w = {bcd_q[38:36], bcd_adj_w, bin_q[MAG_W-1]};
  end

  always_comb begin
    char_pack_w = '0;
    for (int i = 0; i < int'(DIGITS); i++)
      char_pack_w[CODE_W*i +: CODE_W] = CODE_ZERO + {2'b00, bcd_step_w[4*i +: 4]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      stop_q     <= 1'b0;
      char_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (char_start) begin
            state_q <= ST_RUN;
            bin_q   <= char_in;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(MAG_W);
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          bcd_q <= bcd_step_w[38:0];
          bin_q <= {bin_q[MAG_W-2:0], 1'b0};
          cnt_q <= cnt_q - CNT_W'(1);
          // Last iteration: pack the freshly shifted digits straight into the output.
          if (cnt_q == CNT_W'(1)) begin
            state_q    <= ST_DONE;
            stop_q     <= 1'b1;
            char_out_q <= char_pack_w;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          stop_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          stop_q  <= 1'b0;
        end
      endcase
    end
  end

  assign char_busy = busy_q;
  assign char_stop = stop_q;
  assign char_out  = char_out_q;
`else
  logic              stop_q;
  logic [CHAR_W-1:0] char_out_q;
  logic              char_in_unused_w;

  assign char_in_unused_w = ^char_in;

  // Reduced build: acknowledge one cycle later with an all-'0' character string.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stop_q     <= 1'b0;
      char_out_q <= '0;
    end else begin
      stop_q <= char_start;
      if (char_start)
        char_out_q <= {DIGITS{CODE_ZERO}};
    end
  end

  assign char_busy = 1'b0;
  assign char_stop = stop_q;
  assign char_out  = char_out_q;
`endif

endmodule

// File: tb/tb_mix_add_char.sv
// Directed self-checking bench for mix_add_char (full or reduced CHAR build).
module tb_mix_add_char;

  logic        clk = 1'b0;
  logic        reset;
  logic        add_start;
  logic [30:0] add_a, add_b;
  logic        add_stop;
  logic [30:0] add_out;
  logic        add_overflow;
  logic        char_start;
  logic [29:0] char_in;
  logic        char_busy;
  logic        char_stop;
  logic [59:0] char_out;

  int checks = 0;
  int errors = 0;

  localparam logic [30:0] MAXMAG = {1'b0, 30'h3FFF_FFFF};

`ifdef MIX_CHAR_EN
  localparam logic [59:0] EXP_12977699 = {6'd30, 6'd30, 6'd31, 6'd32, 6'd39,
                                          6'd37, 6'd37, 6'd36, 6'd39, 6'd39};
  localparam logic [59:0] EXP_MAX      = {6'd31, 6'd30, 6'd37, 6'd33, 6'd37,
                                          6'd34, 6'd31, 6'd38, 6'd32, 6'd33};
  localparam int EXP_LAT   = 31;
  localparam int EXP_BUSY  = 31;
  localparam int EXP_NSTOP_REISSUE = 1;
`else
  localparam logic [59:0] EXP_12977699 = {10{6'd30}};
  localparam logic [59:0] EXP_MAX      = {10{6'd30}};
  localparam int EXP_LAT   = 1;
  localparam int EXP_BUSY  = 0;
  localparam int EXP_NSTOP_REISSUE = 2;
`endif
  localparam logic [59:0] EXP_ZERO = {10{6'd30}};

  mix_add_char dut (
    .clk          (clk),
    .reset        (reset),
    .add_start    (add_start),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_stop     (add_stop),
    .add_out      (add_out),
    .add_overflow (add_overflow),
    .char_start   (char_start),
    .char_in      (char_in),
    .char_busy    (char_busy),
    .char_stop    (char_stop),
    .char_out     (char_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_add(input string tag, input logic [30:0] a, input logic [30:0] b,
                        input logic [30:0] exp_out, input logic exp_ovf);
    @(negedge clk);
    add_a = a; add_b = b; add_start = 1'b1;
    @(negedge clk);
    add_start = 1'b0;
    chk({tag, "_stop"}, 64'(add_stop), 64'(1));
    chk({tag, "_out"},  64'(add_out),  64'(exp_out));
    chk({tag, "_ovf"},  64'(add_overflow), 64'(exp_ovf));
    @(negedge clk);
    chk({tag, "_stop_low"}, 64'(add_stop), 64'(0));
    chk({tag, "_held"},     64'(add_out),  64'(exp_out));
  endtask

  task automatic run_char(input logic [29:0] v, input bit reissue,
                          output int stop_k, output int n_stop, output int n_busy);
    stop_k = 0; n_stop = 0; n_busy = 0;
    @(negedge clk);
    char_in = v; char_start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (char_busy) n_busy++;
      if (char_stop) begin
        n_stop++;
        if (stop_k == 0) stop_k = k;
      end
      if (k == 1) char_start = 1'b0;
      if (reissue && k == 5) begin char_in = 30'd0; char_start = 1'b1; end
      if (reissue && k == 6) char_start = 1'b0;
    end
  endtask

  initial begin
    int sk, ns, nb;
    reset = 1'b0; add_start = 1'b0; add_a = '0; add_b = '0;
    char_start = 1'b0; char_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_add_out",  64'(add_out), 64'(0));
    chk("rst_add_ovf",  64'(add_overflow), 64'(0));
    chk("rst_add_stop", 64'(add_stop), 64'(0));
    chk("rst_char_out", 64'(char_out), 64'(0));
    chk("rst_busy",     64'(char_busy), 64'(0));
    chk("rst_cstop",    64'(char_stop), 64'(0));
    reset = 1'b1;

    do_add("add_5p7",     {1'b0, 30'd5}, {1'b0, 30'd7},  {1'b0, 30'd12}, 1'b0);
    do_add("add_ovf_pos", MAXMAG,        {1'b0, 30'd1},  {1'b0, 30'd0},  1'b1);
    do_add("add_ovf_neg", {1'b1, MAXMAG[29:0]}, {1'b1, 30'd2}, {1'b1, 30'd1}, 1'b1);
    do_add("add_3m10",    {1'b0, 30'd3}, {1'b1, 30'd10}, {1'b1, 30'd7},  1'b0);
    do_add("add_m100p100",{1'b1, 30'd100}, {1'b0, 30'd100}, {1'b1, 30'd0}, 1'b0);
    do_add("add_big_sub", {1'b0, 30'd50}, {1'b1, 30'd20}, {1'b0, 30'd30}, 1'b0);

    // back-to-back starts
    @(negedge clk);
    add_a = {1'b0, 30'd5}; add_b = {1'b0, 30'd7}; add_start = 1'b1;
    @(negedge clk);
    chk("b2b_stop1", 64'(add_stop), 64'(1));
    chk("b2b_out1",  64'(add_out),  64'({1'b0, 30'd12}));
    add_a = {1'b0, 30'd3}; add_b = {1'b1, 30'd10};
    @(negedge clk);
    add_start = 1'b0;
    chk("b2b_stop2", 64'(add_stop), 64'(1));
    chk("b2b_out2",  64'(add_out),  64'({1'b1, 30'd7}));
    @(negedge clk);
    chk("b2b_stop_low", 64'(add_stop), 64'(0));

    run_char(30'd12977699, 1'b0, sk, ns, nb);
    chk("c1_lat",   64'(sk), 64'(EXP_LAT));
    chk("c1_nstop", 64'(ns), 64'(1));
    chk("c1_busy",  64'(nb), 64'(EXP_BUSY));
    chk("c1_out",   64'(char_out), 64'(EXP_12977699));

    run_char(30'd0, 1'b0, sk, ns, nb);
    chk("c0_lat", 64'(sk), 64'(EXP_LAT));
    chk("c0_out", 64'(char_out), 64'(EXP_ZERO));

    run_char(30'h3FFF_FFFF, 1'b1, sk, ns, nb);
    chk("cmax_lat",   64'(sk), 64'(EXP_LAT));
    chk("cmax_nstop", 64'(ns), 64'(EXP_NSTOP_REISSUE));
    chk("cmax_busy",  64'(nb), 64'(EXP_BUSY));
    chk("cmax_out",   64'(char_out), 64'(EXP_MAX));

    // reset in the middle of a conversion
    @(negedge clk);
    char_in = 30'd12977699; char_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) char_start = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("mid_busy",    64'(char_busy), 64'(0));
    chk("mid_cstop",   64'(char_stop), 64'(0));
    chk("mid_out",     64'(char_out), 64'(0));
    chk("mid_add_out", 64'(add_out), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    ns = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (char_stop) ns++;
    end
    chk("mid_no_stop", 64'(ns), 64'(0));

    run_char(30'd12977699, 1'b0, sk, ns, nb);
    chk("post_lat", 64'(sk), 64'(EXP_LAT));
    chk("post_out", 64'(char_out), 64'(EXP_12977699));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
